// File: rtl/am_lock_rx.sv
// Per-lane receive alignment-marker lock: hunts for one of four lane markers, confirms its
// 2^GAP_W block recurrence and flags marker blocks. Optional error counter: AM_LOCK_RX_ERR_CNT_EN.
module am_lock_rx #(
    parameter int unsigned       HEAD_W    = 2,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       GAP_W     = 14,
    parameter logic [HEAD_W-1:0] CTRL_HEAD = 'b01,
    parameter int unsigned       INV_MAX   = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic              block_lock_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    output logic              marker_v_o,
    output logic              am_lock_o,
    output logic [1:0]        lane_id_o
`ifdef AM_LOCK_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt_o
`endif
);

    localparam int unsigned INV_W = $clog2(INV_MAX + 1);
    localparam logic [GAP_W-1:0] CNT_LAST = '1;
    localparam logic [GAP_W-1:0] CNT_PRE  = CNT_LAST - GAP_W'(1);

    // Marker bytes {b6,b5,b4,b2,b1,b0}; BIP3/BIP7 are excluded.
    localparam logic [47:0] AM_L0 = 48'hB8896F_477690;
    localparam logic [47:0] AM_L1 = 48'h193B0F_E6C4F0;
    localparam logic [47:0] AM_L2 = 48'h649A3A_9B65C5;
    localparam logic [47:0] AM_L3 = 48'hC2865D_3D79A2;

    typedef enum logic [1:0] {StFind1st, StCount1, StComp2nd, StLocked} state_e;

    state_e            state_q, state_d;
    logic [GAP_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [INV_W-1:0]  inv_q, inv_d;
    logic              am_lock_q, am_lock_d;
    logic [1:0]        lane_id_q, lane_id_d;
    logic              marker_v_q, marker_v_d;
    logic              valid_q;
    logic [HEAD_W-1:0] head_q;
    logic [DATA_W-1:0] data_q;

    logic [47:0]      am_body;
    logic [3:0]       lane_hit;
    logic [1:0]       hit_idx;
    logic             head_ok;
    logic             any_hit;
    logic             own_hit;
    logic             slot;
    logic [INV_W-1:0] inv_inc;

    assign am_body = {data_i[55:32], data_i[23:0]};
    assign head_ok = (head_i == CTRL_HEAD);
    assign lane_hit = {am_body == AM_L3, am_body == AM_L2, am_body == AM_L1, am_body == AM_L0};
    assign any_hit = head_ok & (|lane_hit);
    assign own_hit = head_ok & lane_hit[lane_q];
    assign slot    = (cnt_q == CNT_LAST);
    assign inv_inc = inv_q + INV_W'(1);

    always_comb begin
        hit_idx = 2'd0;
        for (int l = 0; l < 4; l++) begin
            if (lane_hit[l]) hit_idx = 2'(l);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        inv_d      = inv_q;
        am_lock_d  = am_lock_q;
        lane_id_d  = lane_id_q;
        marker_v_d = marker_v_q;
        if (!block_lock_i) begin
            state_d   = StFind1st;
            am_lock_d = 1'b0;
            cnt_d     = '0;
            if (valid_i) marker_v_d = 1'b0;
        end else if (valid_i) begin
            marker_v_d = 1'b0;
            cnt_d      = cnt_q + GAP_W'(1);
            unique case (state_q)
                StFind1st: begin
                    cnt_d = '0;
                    if (any_hit) begin
                        lane_d  = hit_idx;
                        state_d = StCount1;
                    end
                end
                StCount1: begin
                    if (cnt_q == CNT_PRE) state_d = StComp2nd;
                end
                StComp2nd: begin
                    // A failed second marker is not reused as a new first marker.
                    if (own_hit) begin
                        am_lock_d = 1'b1;
                        lane_id_d = lane_q;
                        inv_d     = '0;
                        state_d   = StLocked;
                    end else begin
                        state_d = StFind1st;
                    end
                end
                StLocked: begin
                    if (slot) begin
                        if (own_hit) begin
                            inv_d      = '0;
                            marker_v_d = 1'b1;
                        end else begin
                            inv_d = inv_inc;
                            if (inv_inc == INV_W'(INV_MAX)) begin
                                am_lock_d = 1'b0;
                                state_d   = StFind1st;
                            end
                        end
                    end
                end
                default: state_d = StFind1st;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StFind1st;
            cnt_q      <= '0;
            lane_q     <= '0;
            inv_q      <= '0;
            am_lock_q  <= 1'b0;
            lane_id_q  <= '0;
            marker_v_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            inv_q      <= inv_d;
            am_lock_q  <= am_lock_d;
            lane_id_q  <= lane_id_d;
            marker_v_q <= marker_v_d;
            valid_q    <= valid_i;
            if (valid_i) begin
                head_q <= head_i;
                data_q <= data_i;
            end
        end
    end

    assign valid_o    = valid_q;
    assign head_o     = head_q;
    assign data_o     = data_q;
    assign marker_v_o = marker_v_q;
    assign am_lock_o  = am_lock_q;
    assign lane_id_o  = lane_id_q;

`ifdef AM_LOCK_RX_ERR_CNT_EN
    logic [7:0] err_q;
    logic       slot_miss;
    logic       lock_lost;
    logic [8:0] err_sum;

    assign slot_miss = valid_i & block_lock_i & (state_q == StLocked) & slot & ~own_hit;
    assign lock_lost = am_lock_q & ~am_lock_d;
    assign err_sum   = {1'b0, err_q} + {8'd0, slot_miss} + {8'd0, lock_lost};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q <= '0;
        end else begin
            err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_am_lock_rx.sv
// Self-checking bench for am_lock_rx (GAP_W=4): vector table, directed corner sequences and
// random stimulus against a block-counting reference model.
module tb_am_lock_rx;

    localparam int PERIOD  = 16;
    localparam int INV_MAX = 4;

    logic        clk;
    logic        nreset;
    logic        valid;
    logic        bl;
    logic [1:0]  head;
    logic [63:0] data;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        marker_v_o;
    logic        am_lock_o;
    logic [1:0]  lane_id_o;
`ifdef AM_LOCK_RX_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    am_lock_rx #(
        .HEAD_W   (2),
        .DATA_W   (64),
        .GAP_W    (4),
        .CTRL_HEAD(2'b01),
        .INV_MAX  (INV_MAX)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .valid_i     (valid),
        .block_lock_i(bl),
        .head_i      (head),
        .data_i      (data),
        .valid_o     (valid_o),
        .head_o      (head_o),
        .data_o      (data_o),
        .marker_v_o  (marker_v_o),
        .am_lock_o   (am_lock_o),
        .lane_id_o   (lane_id_o)
`ifdef AM_LOCK_RX_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0 hunting, 1 awaiting second marker, 2 locked.
    int          mode_m, since_m, lane_m, bad_m, err_m;
    logic        vo_m, mv_m, lock_m;
    logic [1:0]  ho_m, lid_m;
    logic [63:0] do_m;

    typedef struct {
        logic [1:0]  h1;
        logic [63:0] d1;
        logic [1:0]  h2;
        logic [63:0] d2;
        logic        lock;
        logic [1:0]  lid;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [47:0] pat_of(int lane);
        case (lane)
            0:       return 48'h907647_6F89B8;
            1:       return 48'hF0C4E6_0F3B19;
            2:       return 48'hC5659B_3A9A64;
            default: return 48'hA2793D_5D86C2;
        endcase
    endfunction

    function automatic logic [63:0] am_blk(int lane, logic [7:0] b3, logic [7:0] b7);
        logic [47:0] p;
        logic [63:0] d;
        p = pat_of(lane);
        d[7:0]   = p[47:40];
        d[15:8]  = p[39:32];
        d[23:16] = p[31:24];
        d[31:24] = b3;
        d[39:32] = p[23:16];
        d[47:40] = p[15:8];
        d[55:48] = p[7:0];
        d[63:56] = b7;
        return d;
    endfunction

    function automatic int which_lane(logic [1:0] h, logic [63:0] d);
        for (int l = 0; l < 4; l++) begin
            logic [63:0] ref_d;
            ref_d = am_blk(l, d[31:24], d[63:56]);
            if (h == 2'b01 && d == ref_d) return l;
        end
        return -1;
    endfunction

    task automatic err_bump();
        if (err_m < 255) err_m++;
    endtask

    task automatic model_reset();
        mode_m = 0; since_m = 0; lane_m = 0; bad_m = 0; err_m = 0;
        vo_m = 0; mv_m = 0; lock_m = 0; ho_m = 0; lid_m = 0; do_m = 0;
    endtask

    task automatic model_step();
        int m;
        vo_m = valid;
        if (valid) begin
            ho_m = head;
            do_m = data;
            mv_m = 1'b0;
        end
        if (!bl) begin
            if (lock_m) err_bump();
            lock_m = 1'b0;
            mode_m = 0;
            since_m = 0;
        end else if (valid) begin
            m = which_lane(head, data);
            case (mode_m)
                0: if (m >= 0) begin
                    lane_m = m; since_m = 0; mode_m = 1;
                end
                1: begin
                    since_m++;
                    if (since_m == PERIOD) begin
                        if (m == lane_m) begin
                            lock_m = 1'b1; lid_m = 2'(lane_m); bad_m = 0; mode_m = 2; since_m = 0;
                        end else begin
                            mode_m = 0;
                        end
                    end
                end
                default: begin
                    since_m++;
                    if (since_m == PERIOD) begin
                        since_m = 0;
                        if (m == lane_m) begin
                            bad_m = 0; mv_m = 1'b1;
                        end else begin
                            bad_m++;
                            err_bump();
                            if (bad_m == INV_MAX) begin
                                lock_m = 1'b0; mode_m = 0; err_bump();
                            end
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("valid_o", 64'(valid_o), 64'(vo_m));
        chk("head_o", 64'(head_o), 64'(ho_m));
        chk("data_o", data_o, do_m);
        chk("marker_v_o", 64'(marker_v_o), 64'(mv_m));
        chk("am_lock_o", 64'(am_lock_o), 64'(lock_m));
        chk("lane_id_o", 64'(lane_id_o), 64'(lid_m));
`ifdef AM_LOCK_RX_ERR_CNT_EN
        chk("err_cnt_o", 64'(err_cnt_o), 64'(err_m));
`endif
    endtask

    task automatic send(input logic v, input logic b, input logic [1:0] h, input logic [63:0] d);
        valid = v; bl = b; head = h; data = d;
        tick();
    endtask

    task automatic send_blk(input logic [1:0] h, input logic [63:0] d);
        send(1'b1, 1'b1, h, d);
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) send_blk(2'b10, {$urandom, $urandom});
    endtask

    task automatic do_reset();
        nreset = 1'b0; valid = 1'b0; bl = 1'b0; head = '0; data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst am_lock", 64'(am_lock_o), 64'd0);
        chk("rst lane_id", 64'(lane_id_o), 64'd0);
        chk("rst marker_v", 64'(marker_v_o), 64'd0);
        chk("rst data_o", data_o, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic lock_lane(input int lane);
        send_blk(2'b01, am_blk(lane, 8'h11, 8'h22));
        filler(PERIOD - 1);
        send_blk(2'b01, am_blk(lane, 8'h33, 8'h44));
    endtask

    initial begin
        logic [63:0] mk;
        int g, ph, lane_r, r;

        tbl[0] = '{2'b01, am_blk(0, 8'h00, 8'h00), 2'b01, am_blk(0, 8'h00, 8'h00), 1'b1, 2'd0};
        tbl[1] = '{2'b01, am_blk(1, 8'hA5, 8'h5A), 2'b01, am_blk(1, 8'h3C, 8'hC3), 1'b1, 2'd1};
        tbl[2] = '{2'b01, am_blk(3, 8'h00, 8'h00), 2'b10, am_blk(3, 8'h00, 8'h00), 1'b0, 2'd0};
        tbl[3] = '{2'b01, am_blk(2, 8'h00, 8'h00), 2'b01,
                   am_blk(2, 8'h00, 8'h00) ^ 64'h00FF_0000_0000_0000, 1'b0, 2'd0};
        tbl[4] = '{2'b01, am_blk(0, 8'h00, 8'h00), 2'b01,
                   am_blk(0, 8'h00, 8'h00) ^ 64'h0000_0000_0000_0001, 1'b0, 2'd0};
        tbl[5] = '{2'b01, am_blk(2, 8'h00, 8'h00), 2'b01, am_blk(1, 8'h00, 8'h00), 1'b0, 2'd0};
        tbl[6] = '{2'b01, am_blk(3, 8'hFF, 8'h01), 2'b01, am_blk(3, 8'h7E, 8'hE7), 1'b1, 2'd3};
        tbl[7] = '{2'b00, am_blk(2, 8'h00, 8'h00), 2'b01, am_blk(2, 8'h00, 8'h00), 1'b0, 2'd0};

        nreset = 1'b1; valid = 1'b0; bl = 1'b0; head = '0; data = '0;
        #1 nreset = 1'b0;
        model_reset();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            send_blk(tbl[i].h1, tbl[i].d1);
            filler(PERIOD - 1);
            send_blk(tbl[i].h2, tbl[i].d2);
            chk($sformatf("vec%0d lock", i), 64'(am_lock_o), 64'(tbl[i].lock));
            chk($sformatf("vec%0d lane", i), 64'(lane_id_o), 64'(tbl[i].lid));
        end

        // Lane 2 lock, then flagged marker at block 32
        do_reset();
        send_blk(2'b01, am_blk(2, 8'h01, 8'h02));
        filler(PERIOD - 1);
        chk("t1 no early lock", 64'(am_lock_o), 64'd0);
        send_blk(2'b01, am_blk(2, 8'h03, 8'h04));
        chk("t1 lock", 64'(am_lock_o), 64'd1);
        chk("t1 lane", 64'(lane_id_o), 64'd2);
        chk("t1 2nd unflagged", 64'(marker_v_o), 64'd0);
        filler(PERIOD - 1);
        mk = am_blk(2, 8'h05, 8'h06);
        send_blk(2'b01, mk);
        chk("t1 marker_v", 64'(marker_v_o), 64'd1);
        chk("t1 marker data", data_o, mk);
        filler(1);
        chk("t1 marker_v 1 cyc", 64'(marker_v_o), 64'd0);

        // Wrong second lane; it is not reused as first marker
        do_reset();
        send_blk(2'b01, am_blk(1, 8'h00, 8'h00));
        filler(PERIOD - 1);
        send_blk(2'b01, am_blk(3, 8'h00, 8'h00));
        chk("t2 no lock 16", 64'(am_lock_o), 64'd0);
        filler(PERIOD - 1);
        send_blk(2'b01, am_blk(3, 8'h00, 8'h00));
        chk("t2 no lock 32", 64'(am_lock_o), 64'd0);
        filler(PERIOD - 1);
        send_blk(2'b01, am_blk(3, 8'h00, 8'h00));
        chk("t2 lock 48", 64'(am_lock_o), 64'd1);
        chk("t2 lane", 64'(lane_id_o), 64'd3);

        // Three bad slots then good, twice: inv count must have cleared
        do_reset();
        lock_lane(0);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 3; k++) begin
                filler(PERIOD - 1);
                send_blk(2'b01, am_blk(0, 8'h00, 8'h00) ^ 64'h0000_0000_0000_FF00);
                chk("t3 held", 64'(am_lock_o), 64'd1);
                chk("t3 no flag", 64'(marker_v_o), 64'd0);
            end
            filler(PERIOD - 1);
            send_blk(2'b01, am_blk(0, 8'h00, 8'h00));
            chk("t3 good flag", 64'(marker_v_o), 64'd1);
        end

        // Four bad slots drop lock
        do_reset();
        lock_lane(0);
        for (int k = 0; k < 4; k++) begin
            filler(PERIOD - 1);
            send_blk(2'b01, am_blk(1, 8'h00, 8'h00));
            chk("t4 lock", 64'(am_lock_o), (k == 3) ? 64'd0 : 64'd1);
        end
        chk("t4 lane held", 64'(lane_id_o), 64'd0);
`ifdef AM_LOCK_RX_ERR_CNT_EN
        chk("t4 err_cnt", 64'(err_cnt_o), 64'd5);
`endif

        // Valid gap mid-period
        do_reset();
        lock_lane(1);
        filler(4);
        for (int k = 0; k < 7; k++) begin
            send(1'b0, 1'b1, 2'b01, am_blk(1, 8'h00, 8'h00));
            chk("t5 valid_o low", 64'(valid_o), 64'd0);
        end
        filler(PERIOD - 5);
        chk("t5 held", 64'(am_lock_o), 64'd1);
        send_blk(2'b01, am_blk(1, 8'h00, 8'h00));
        chk("t5 marker_v", 64'(marker_v_o), 64'd1);
        chk("t5 lock", 64'(am_lock_o), 64'd1);

        // Block lock drop while locked, and together with a matching second marker
        do_reset();
        lock_lane(3);
        filler(5);
        send(1'b1, 1'b0, 2'b10, 64'h0);
        chk("t6 bl drop", 64'(am_lock_o), 64'd0);
        chk("t6 lane held", 64'(lane_id_o), 64'd3);
        do_reset();
        send_blk(2'b01, am_blk(2, 8'h00, 8'h00));
        filler(PERIOD - 1);
        send(1'b1, 1'b0, 2'b01, am_blk(2, 8'h00, 8'h00));
        chk("t6 bl wins", 64'(am_lock_o), 64'd0);

        // Async reset pulse during COUNT_1
        do_reset();
        send_blk(2'b01, am_blk(0, 8'h00, 8'h00));
        filler(5);
        valid = 1'b0;
        #2 nreset = 1'b0;
        #1;
        chk("t6 arst valid_o", 64'(valid_o), 64'd0);
        chk("t6 arst data_o", data_o, 64'd0);
        chk("t6 arst head_o", 64'(head_o), 64'd0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        filler(PERIOD - 7);
        send_blk(2'b01, am_blk(0, 8'h00, 8'h00));
        chk("t6 restart no lock", 64'(am_lock_o), 64'd0);
        filler(PERIOD - 1);
        send_blk(2'b01, am_blk(0, 8'h00, 8'h00));
        chk("t6 relock", 64'(am_lock_o), 64'd1);

        // Random stream with a periodic marker for a rotating lane
        do_reset();
        g = 0;
        ph = $urandom_range(0, PERIOD - 1);
        lane_r = $urandom_range(0, 3);
        for (int c = 0; c < 4000; c++) begin
            if (c % 700 == 699) begin
                lane_r = $urandom_range(0, 3);
                ph = $urandom_range(0, PERIOD - 1);
            end
            valid = ($urandom % 10) < 8;
            bl = ($urandom % 300) != 0;
            r = $urandom % 40;
            if (valid && (g % PERIOD == ph)) begin
                head = 2'b01;
                if (r < 33) data = am_blk(lane_r, 8'($urandom), 8'($urandom));
                else if (r < 36) data = am_blk($urandom_range(0, 3), 8'h00, 8'h00);
                else data = {$urandom, $urandom};
            end else if (r == 0) begin
                head = 2'b01;
                data = am_blk($urandom_range(0, 3), 8'($urandom), 8'($urandom));
            end else begin
                head = 2'($urandom);
                data = {$urandom, $urandom};
            end
            if (valid) g++;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
